// File: rtl/scsi_xfer_seq.sv
// SCSI chip access sequencer: arbitrates CPU register cycles and DMA byte
// transfers, times setup/strobe/hold phases and tracks the FIFO byte lane.
//
// state      | meaning
// IDLE       | no access in progress, arbitration happens here
// CPU_SETUP  | SCSI_CS valid ahead of the strobe
// CPU_STROBE | RE/WE asserted for a CPU register access
// CPU_HOLD   | SCSI_CS held after the strobe, last cycle terminates the CPU
// DMA_SETUP  | DACK valid ahead of the strobe
// DMA_STROBE | RE/WE asserted for a DMA byte
// DMA_HOLD   | DACK held after the strobe, last cycle advances the byte lane
module scsi_xfer_seq #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CPUREQ,
  input  logic       RW,
  input  logic       DMAENA,
  input  logic       DMADIR,
  input  logic       DREQ,
  input  logic       FIFOFULL,
  input  logic       FIFOEMPTY,
  input  logic       BOCLR,
  output logic       SCSI_CS,
  output logic       RE,
  output logic       WE,
  output logic       DACK,
  output logic       CPU2S,
  output logic       S2CPU,
  output logic       F2S,
  output logic       S2F,
  output logic       SET_DSACK,
  output logic       INCBO,
  output logic       INCNI,
  output logic       INCNO,
  output logic [1:0] BO
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_SETUP,
    CPU_STROBE,
    CPU_HOLD,
    DMA_SETUP,
    DMA_STROBE,
    DMA_HOLD
  } state_t;

  // Phase counters hold (length - 1) and the phase ends when they reach zero.
  localparam logic [1:0] LD_SETUP  = 2'(T_SETUP - 1);
  localparam logic [1:0] LD_STROBE = 2'(T_STROBE - 1);
  localparam logic [1:0] LD_HOLD   = 2'(T_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       cap_rd_q, cap_rd_d;
  logic       last_dma_q, last_dma_d;
  logic       cpu_done_q;
  logic       run_q;
  logic [1:0] bo_q;

  logic fifo_ok;
  logic dma_elig;
  logic cpu_elig;
  logic last_tick;

  assign fifo_ok   = DMADIR ? ~FIFOFULL : ~FIFOEMPTY;
  assign dma_elig  = DMAENA & DREQ & ((bo_q != 2'd0) | fifo_ok);
  assign cpu_elig  = CPUREQ & ~cpu_done_q;
  assign last_tick = (cnt_q == 2'd0);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      cap_rd_q   <= 1'b0;
      last_dma_q <= 1'b1;
      cpu_done_q <= 1'b0;
      run_q      <= 1'b0;
      bo_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_rd_q   <= cap_rd_d;
      last_dma_q <= last_dma_d;
      run_q      <= 1'b1;
      if (SET_DSACK)
        cpu_done_q <= 1'b1;
      else if (!CPUREQ)
        cpu_done_q <= 1'b0;
      if (BOCLR)
        bo_q <= 2'd0;
      else if (INCBO)
        bo_q <= bo_q + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_rd_d   = cap_rd_q;
    last_dma_d = last_dma_q;
    case (state_q)
      IDLE: begin
        // run_q holds off arbitration for the first edge after reset release.
        if (run_q) begin
          if (cpu_elig && (!dma_elig || last_dma_q)) begin
            state_d    = CPU_SETUP;
            cnt_d      = LD_SETUP;
            cap_rd_d   = RW;
            last_dma_d = 1'b0;
          end else if (dma_elig) begin
            state_d    = DMA_SETUP;
            cnt_d      = LD_SETUP;
            cap_rd_d   = DMADIR;
            last_dma_d = 1'b1;
          end
        end
      end
      CPU_SETUP, DMA_SETUP: begin
        if (last_tick) begin
          state_d = (state_q == CPU_SETUP) ? CPU_STROBE : DMA_STROBE;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CPU_STROBE, DMA_STROBE: begin
        if (last_tick) begin
          state_d = (state_q == CPU_STROBE) ? CPU_HOLD : DMA_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CPU_HOLD, DMA_HOLD: begin
        if (last_tick)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_cpu, in_dma, in_strobe;

  assign in_cpu    = (state_q == CPU_SETUP) | (state_q == CPU_STROBE) | (state_q == CPU_HOLD);
  assign in_dma    = (state_q == DMA_SETUP) | (state_q == DMA_STROBE) | (state_q == DMA_HOLD);
  assign in_strobe = (state_q == CPU_STROBE) | (state_q == DMA_STROBE);

  assign SCSI_CS   = in_cpu;
  assign DACK      = in_dma;
  assign RE        = in_strobe & cap_rd_q;
  assign WE        = in_strobe & ~cap_rd_q;
  assign CPU2S     = in_cpu & ~cap_rd_q;
  assign S2CPU     = ((state_q == CPU_STROBE) | (state_q == CPU_HOLD)) & cap_rd_q;
  assign F2S       = in_dma & ~cap_rd_q;
  assign S2F       = ((state_q == DMA_STROBE) | (state_q == DMA_HOLD)) & cap_rd_q;
  assign SET_DSACK = (state_q == CPU_HOLD) & last_tick;
  assign INCBO     = (state_q == DMA_HOLD) & last_tick;
  assign INCNI     = INCBO & (bo_q == 2'd3) & cap_rd_q;
  assign INCNO     = INCBO & (bo_q == 2'd3) & ~cap_rd_q;
  assign BO        = bo_q;

endmodule

// File: tb/tb_scsi_xfer_seq.sv
// Directed bench for scsi_xfer_seq: CPU read/write, DMA streaming, arbitration,
// FIFO-empty gating, mid-cycle reset and byte-pointer clear.
module tb_scsi_xfer_seq;

  logic       CLK;
  logic       nRESET;
  logic       CPUREQ, RW, DMAENA, DMADIR, DREQ, FIFOFULL, FIFOEMPTY, BOCLR;
  logic       SCSI_CS, RE, WE, DACK, CPU2S, S2CPU, F2S, S2F;
  logic       SET_DSACK, INCBO, INCNI, INCNO;
  logic [1:0] BO;
  logic [11:0] ov;

  int n_assert = 0;
  int n_fail   = 0;

  scsi_xfer_seq dut (
    .CLK(CLK), .nRESET(nRESET), .CPUREQ(CPUREQ), .RW(RW), .DMAENA(DMAENA),
    .DMADIR(DMADIR), .DREQ(DREQ), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
    .BOCLR(BOCLR), .SCSI_CS(SCSI_CS), .RE(RE), .WE(WE), .DACK(DACK),
    .CPU2S(CPU2S), .S2CPU(S2CPU), .F2S(F2S), .S2F(S2F), .SET_DSACK(SET_DSACK),
    .INCBO(INCBO), .INCNI(INCNI), .INCNO(INCNO), .BO(BO)
  );

  assign ov = {SCSI_CS, RE, WE, DACK, CPU2S, S2CPU, F2S, S2F,
               SET_DSACK, INCBO, INCNI, INCNO};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    CPUREQ = 0; RW = 0; DMAENA = 0; DMADIR = 0; DREQ = 0;
    FIFOFULL = 0; FIFOEMPTY = 0; BOCLR = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    nRESET = 0;
    tick(); tick();
    nRESET = 1;
    tick(); tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    nRESET = 0;
    CPUREQ = 1; RW = 1;
    tick(); tick();
    n_assert++;
    if (ov !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000000000000", ov);
    end
    n_assert++;
    if (BO !== 2'd0) begin
      n_fail++; $display("FAIL reset_bo: got %0d want 0", BO);
    end
    nRESET = 1;
    tick();
    n_assert++;
    if (SCSI_CS !== 1'b0) begin
      n_fail++; $display("FAIL release_first_edge_cs: got %b want 0", SCSI_CS);
    end
    tick();
    n_assert++;
    if (SCSI_CS !== 1'b1) begin
      n_fail++; $display("FAIL release_second_edge_cs: got %b want 1", SCSI_CS);
    end
    clear_inputs();
  endtask

  task automatic test_cpu_access(input logic rw);
    logic [11:0] exp;
    do_reset();
    CPUREQ = 1; RW = rw;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = {1'(c <= 4),
             rw && c >= 2 && c <= 3,
             !rw && c >= 2 && c <= 3,
             1'b0,
             !rw && c <= 4,
             rw && c >= 2 && c <= 4,
             1'b0, 1'b0,
             1'(c == 4),
             1'b0, 1'b0, 1'b0};
      n_assert++;
      if (ov !== exp) begin
        n_fail++; $display("FAIL cpu_rw%0b_cycle%0d: got %b want %b", rw, c, ov, exp);
      end
      if (c == 2) RW = ~rw;
    end
    CPUREQ = 0;
    tick(); tick();
    CPUREQ = 1; RW = rw;
    tick();
    n_assert++;
    if (SCSI_CS !== 1'b1) begin
      n_fail++; $display("FAIL cpu_regrant_after_low: got %b want 1", SCSI_CS);
    end
    clear_inputs();
  endtask

  task automatic test_dma_stream;
    logic [13:0] exp;
    int p, bytei;
    do_reset();
    DMAENA = 1; DMADIR = 1; DREQ = 1; FIFOFULL = 0; FIFOEMPTY = 1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c <= 25) begin
        p = (c - 1) % 5;
        bytei = (c - 1) / 5;
        exp = {1'b0, 1'(p == 1 || p == 2), 1'b0, 1'(p < 4), 1'b0, 1'b0, 1'b0,
               1'(p >= 1 && p <= 3), 1'b0, 1'(p == 3),
               1'(p == 3 && bytei % 4 == 3), 1'b0,
               2'((bytei + ((p == 4) ? 1 : 0)) % 4)};
      end else begin
        exp = {12'h000, 2'd1};
      end
      n_assert++;
      if ({ov, BO} !== exp) begin
        n_fail++; $display("FAIL dma_stream_cycle%0d: got %b want %b", c, {ov, BO}, exp);
      end
      if (c == 21) begin
        DREQ = 0; DMAENA = 0;
      end
    end
    clear_inputs();
  endtask

  task automatic test_arbitration;
    logic grants [6];
    int ng = 0, both = 0, low = 0;
    logic prev_cs = 0, prev_dack = 0;
    do_reset();
    CPUREQ = 1; RW = 1; DMAENA = 1; DREQ = 1; DMADIR = 1; FIFOFULL = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick();
      if (SCSI_CS && DACK) both++;
      if (SCSI_CS && !prev_cs && ng < 6) begin grants[ng] = 1'b0; ng++; end
      if (DACK && !prev_dack && ng < 6) begin grants[ng] = 1'b1; ng++; end
      prev_cs = SCSI_CS; prev_dack = DACK;
      if (SET_DSACK) low = 2;
      if (low > 0) begin CPUREQ = 0; low--; end
      else CPUREQ = 1;
    end
    n_assert++;
    if (ng !== 6) begin
      n_fail++; $display("FAIL arb_grant_count: got %0d want 6", ng);
    end
    for (int i = 0; i < ng; i++) begin
      n_assert++;
      if (grants[i] !== 1'(i % 2)) begin
        n_fail++; $display("FAIL arb_grant%0d (0=cpu 1=dma): got %0d want %0d", i, grants[i], i % 2);
      end
    end
    n_assert++;
    if (both !== 0) begin
      n_fail++; $display("FAIL arb_cs_dack_overlap: got %0d cycles want 0", both);
    end
    clear_inputs();
  endtask

  task automatic test_dma_fifo_empty;
    int dack_n = 0, incbo_n = 0, incno_n = 0, f2s_bad = 0;
    do_reset();
    DMAENA = 1; DREQ = 1; DMADIR = 0; FIFOEMPTY = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (DACK) dack_n++;
    end
    n_assert++;
    if (dack_n !== 0) begin
      n_fail++; $display("FAIL empty_bo0_dack: got %0d cycles want 0", dack_n);
    end
    FIFOEMPTY = 0;
    for (int c = 0; c < 30 && incbo_n < 2; c++) begin
      tick();
      if (INCBO) incbo_n++;
    end
    n_assert++;
    if (incbo_n !== 2) begin
      n_fail++; $display("FAIL empty_prefill_timeout: got %0d bytes want 2", incbo_n);
    end
    FIFOEMPTY = 1;
    dack_n = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) begin
        n_assert++;
        if (BO !== 2'd2) begin
          n_fail++; $display("FAIL empty_bo_before: got %0d want 2", BO);
        end
      end
      if (DACK) dack_n++;
      if (INCNO) incno_n++;
      if (F2S !== DACK) f2s_bad++;
    end
    n_assert++;
    if (dack_n !== 8) begin
      n_fail++; $display("FAIL empty_bo2_dack: got %0d cycles want 8", dack_n);
    end
    n_assert++;
    if (incno_n !== 1) begin
      n_fail++; $display("FAIL empty_incno: got %0d pulses want 1", incno_n);
    end
    n_assert++;
    if (f2s_bad !== 0) begin
      n_fail++; $display("FAIL empty_f2s_track: got %0d bad cycles want 0", f2s_bad);
    end
    n_assert++;
    if (BO !== 2'd0) begin
      n_fail++; $display("FAIL empty_bo_after: got %0d want 0", BO);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_cycle;
    do_reset();
    DMAENA = 1; DMADIR = 1; DREQ = 1; FIFOFULL = 0;
    repeat (7) tick();
    n_assert++;
    if ({RE, DACK, S2F, BO} !== 5'b111_01) begin
      n_fail++; $display("FAIL midrst_pre: got %b want 11101", {RE, DACK, S2F, BO});
    end
    #2 nRESET = 0;
    #1;
    n_assert++;
    if ({ov, BO} !== 14'd0) begin
      n_fail++; $display("FAIL midrst_async: got %b want 0", {ov, BO});
    end
    tick();
    n_assert++;
    if ({ov, BO} !== 14'd0) begin
      n_fail++; $display("FAIL midrst_held: got %b want 0", {ov, BO});
    end
    nRESET = 1;
    clear_inputs();
  endtask

  task automatic test_boclr;
    logic found;
    do_reset();
    DMAENA = 1; DREQ = 1; DMADIR = 0; FIFOEMPTY = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (INCBO && BO == 2'd3) found = 1;
    end
    n_assert++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL boclr_wrap_timeout: got %b want 1", found);
    end
    n_assert++;
    if ({INCNI, INCNO} !== 2'b01) begin
      n_fail++; $display("FAIL boclr_wrap_incno: got %b want 01", {INCNI, INCNO});
    end
    BOCLR = 1;
    tick();
    BOCLR = 0;
    n_assert++;
    if ({BO, INCNO} !== 3'b00_0) begin
      n_fail++; $display("FAIL boclr_wrap_bo: got %b want 000", {BO, INCNO});
    end
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (INCBO && BO == 2'd1) found = 1;
    end
    n_assert++;
    if ({found, INCNI, INCNO} !== 3'b100) begin
      n_fail++; $display("FAIL boclr_mid_pulse: got %b want 100", {found, INCNI, INCNO});
    end
    BOCLR = 1;
    tick();
    BOCLR = 0;
    n_assert++;
    if (BO !== 2'd0) begin
      n_fail++; $display("FAIL boclr_wins_over_incbo: got %0d want 0", BO);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    nRESET = 0;
    test_reset();
    test_cpu_access(1'b1);
    test_cpu_access(1'b0);
    test_dma_stream();
    test_arbitration();
    test_dma_fifo_empty();
    test_reset_mid_cycle();
    test_boclr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
